// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if: CPU register port bundle for the sprite motion controller
interface sprite_motion_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous sprite position sequencer with bounce/wrap and tear-free commit
module sprite_motion_ctrl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                frame_int,
  sprite_motion_ctrl_if.slave bus,
  output logic signed [15:0]  offset_x,
  output logic signed [15:0]  offset_y,
  output logic                frame_tick
);
  localparam int MAXX = SCREEN_W - SPRITE_W;
  localparam int MAXY = SCREEN_H - SPRITE_H;

  typedef enum logic [1:0] {WAIT, UPD_X, UPD_Y, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic               fedge_q, fedge_d;
  logic signed [15:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [15:0] off_x_q, off_x_d, off_y_q, off_y_d;
  logic [15:0]        vel_q, vel_d, rdata_q, rdata_d;
  logic               run_q, run_d, mode_q, mode_d, overrun_q, overrun_d, tick_q, tick_d;
  logic [11:0]        cnt_q, cnt_d;
  logic               busy;
  logic [23:0]        upd_x, upd_y;

  // One axis step: returns {new_velocity, new_position}; int arithmetic covers the 17-bit sum exactly
  function automatic logic [23:0] step(input logic signed [15:0] p, input logic signed [7:0] v,
                                       input logic wrap, input int mx, input int scr, input int spr);
    int n, r;
    logic signed [7:0] nv;
    n  = int'(p) + int'(v);
    r  = n;
    nv = v;
    if (wrap)
      r = n >= scr ? n - scr - spr : (n < -spr ? n + scr + spr : n);
    else if (n < 0 || n > mx) begin
      nv = v == -8'sd128 ? 8'sd127 : -v;
      r  = n < 0 ? -n : 2 * mx - n;
      r  = r < 0 ? 0 : (r > mx ? mx : r);
    end
    return {nv, r[15:0]};
  endfunction

  assign busy       = state_q != WAIT;
  assign upd_x      = step(pos_x_q, vel_q[7:0], mode_q, MAXX, SCREEN_W, SPRITE_W);
  assign upd_y      = step(pos_y_q, vel_q[15:8], mode_q, MAXY, SCREEN_H, SPRITE_H);
  assign offset_x   = off_x_q;
  assign offset_y   = off_y_q;
  assign frame_tick = tick_q;
  assign bus.rdata  = rdata_q;

  // Frame sequencer: one edge starts a fixed X, Y, commit walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    state_d = fedge_q ? UPD_X : WAIT;
      UPD_X:   state_d = UPD_Y;
      UPD_Y:   state_d = COMMIT;
      default: state_d = WAIT;
    endcase
  end

  // Datapath: edge detect, axis updates, commit, then CPU accesses last so a write overrides the FSM
  always_comb begin
    sync_d    = {sync_q[1:0], frame_int};
    fedge_d   = sync_q[1] & ~sync_q[2];
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    vel_d     = vel_q;
    off_x_d   = off_x_q;
    off_y_d   = off_y_q;
    run_d     = run_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    overrun_d = overrun_q | (fedge_q & busy);
    if (state_q == UPD_X && run_q) {vel_d[7:0], pos_x_d} = upd_x;
    if (state_q == UPD_Y && run_q) {vel_d[15:8], pos_y_d} = upd_y;
    if (state_q == COMMIT) begin
      off_x_d = pos_x_q;
      off_y_d = pos_y_q;
      cnt_d   = cnt_q + 12'd1;
      tick_d  = 1'b1;
    end
    if (bus.wr_en)
      case (bus.addr)
        2'd0: pos_x_d = bus.wdata;
        2'd1: pos_y_d = bus.wdata;
        2'd2: vel_d   = bus.wdata;
        default: begin
          run_d  = bus.wdata[0];
          mode_d = bus.wdata[1];
          if (bus.wdata[3]) overrun_d = 1'b0;
        end
      endcase
    rdata_d = !bus.rd_en ? rdata_q :
              bus.addr == 2'd0 ? pos_x_q :
              bus.addr == 2'd1 ? pos_y_q :
              bus.addr == 2'd2 ? vel_q : {cnt_q, overrun_q, busy, mode_q, run_q};
  end

  // State registers with asynchronous clear so a reset mid-update zeroes outputs at once
  always_ff @(posedge clk_sys or negedge reset)
    if (!reset) begin
      state_q   <= WAIT;
      sync_q    <= '0;
      fedge_q   <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      vel_q     <= '0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      rdata_q   <= '0;
      run_q     <= 1'b0;
      mode_q    <= 1'b0;
      overrun_q <= 1'b0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      fedge_q   <= fedge_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      vel_q     <= vel_d;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
      rdata_q   <= rdata_d;
      run_q     <= run_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed and randomized checks against a frame-level motion model
module tb_sprite_motion_ctrl;
  localparam int MAXX = 736;
  localparam int MAXY = 416;

  logic clk_sys = 0, reset = 0, frame_int = 0;
  logic signed [15:0] offset_x, offset_y;
  logic frame_tick;
  logic [15:0] d;
  int checks = 0, failures = 0;
  int mx, my, mvx, mvy, mox, moy, mcnt;
  bit mrun, mmode, movr;

  sprite_motion_ctrl_if bus();

  sprite_motion_ctrl dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .frame_int (frame_int),
    .bus       (bus),
    .offset_x  (offset_x),
    .offset_y  (offset_y),
    .frame_tick(frame_tick)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int nxt(int p, int v, int lim, int scr, int spr, bit wrap, output int nv);
    int n;
    n  = p + v;
    nv = v;
    if (wrap) begin
      if (n >= scr) return n - (scr + spr);
      if (n < -spr) return n + (scr + spr);
      return n;
    end
    if (n >= 0 && n <= lim) return n;
    nv = (v == -128) ? 127 : -v;
    n  = (n < 0) ? -n : 2 * lim - n;
    if (n < 0) return 0;
    if (n > lim) return lim;
    return n;
  endfunction

  function automatic int ctrl_exp();
    return (mcnt << 4) | (int'(movr) << 3) | (int'(mmode) << 1) | int'(mrun);
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mvx = 0; mvy = 0; mox = 0; moy = 0; mcnt = 0;
    mrun = 0; mmode = 0; movr = 0;
  endtask

  task automatic model_frame();
    int nv;
    if (mrun) begin
      mx = nxt(mx, mvx, MAXX, 800, 64, mmode, nv); mvx = nv;
      my = nxt(my, mvy, MAXY, 480, 64, mmode, nv); mvy = nv;
    end
    mox = mx; moy = my;
    mcnt = (mcnt + 1) % 4096;
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] w);
    bus.wr_en = 1; bus.addr = a; bus.wdata = w;
    tick();
    bus.wr_en = 0;
    case (a)
      2'd0: mx = int'($signed(w));
      2'd1: my = int'($signed(w));
      2'd2: begin mvx = int'($signed(w[7:0])); mvy = int'($signed(w[15:8])); end
      default: begin mrun = w[0]; mmode = w[1]; if (w[3]) movr = 0; end
    endcase
  endtask

  task automatic rd(logic [1:0] a, output logic [15:0] r);
    bus.rd_en = 1; bus.addr = a;
    tick();
    bus.rd_en = 0;
    r = bus.rdata;
  endtask

  task automatic frame(string tag);
    int n;
    n = 0;
    frame_int = 1;
    while (!frame_tick && n < 20) begin
      tick();
      n++;
      if (n == 3) frame_int = 0;
    end
    frame_int = 0;
    model_frame();
    check({tag, " latency"}, n, 7);
    check({tag, " x"}, offset_x, mox);
    check({tag, " y"}, offset_y, moy);
    tick();
  endtask

  initial begin
    int extra;
    bus.wr_en = 0; bus.rd_en = 0; bus.addr = 0; bus.wdata = 0;
    model_reset();
    repeat (3) tick();
    check("rst x", offset_x, 0);
    check("rst y", offset_y, 0);
    check("rst tick", frame_tick, 0);
    check("rst rdata", bus.rdata, 0);
    reset = 1;
    tick();
    rd(2'd3, d);
    check("rst ctrl", d, 0);

    wr(2'd0, 16'd100); wr(2'd1, 16'd50); wr(2'd2, 16'hFD05); wr(2'd3, 16'h0001);
    frame("lin1"); check("lin1 cx", offset_x, 105); check("lin1 cy", offset_y, 47);
    frame("lin2"); check("lin2 cx", offset_x, 110); check("lin2 cy", offset_y, 44);
    frame("lin3"); check("lin3 cx", offset_x, 115); check("lin3 cy", offset_y, 41);

    wr(2'd0, 16'd734); wr(2'd1, 16'd2); wr(2'd2, 16'hF905);
    frame("bnc1"); check("bnc1 cx", offset_x, 733); check("bnc1 cy", offset_y, 5);
    rd(2'd2, d); check("bnc1 vel", d, 16'h07FB);
    wr(2'd0, 16'd10); wr(2'd2, 16'h0080);
    frame("bnc2"); check("bnc2 cx", offset_x, 118);
    rd(2'd2, d); check("bnc2 vel", d, 16'h007F);

    wr(2'd3, 16'h0003); wr(2'd0, 16'd798); wr(2'd2, 16'h0004);
    frame("wrp1"); check("wrp1 cx", offset_x, -62);
    wr(2'd0, 16'hFFC1); wr(2'd2, 16'h00FE);
    frame("wrp2"); check("wrp2 cx", offset_x, 799);

    wr(2'd3, 16'h0001); wr(2'd0, 16'd100); wr(2'd1, 16'd100); wr(2'd2, 16'h0101);
    frame_int = 1;
    repeat (3) tick();
    frame_int = 0;
    tick();
    bus.wr_en = 1; bus.addr = 2'd0; bus.wdata = 16'd200;
    tick();
    bus.wr_en = 0;
    repeat (2) tick();
    check("col tick", frame_tick, 1);
    model_frame();
    mx = 200; mox = 200;
    check("col x", offset_x, 200);
    check("col y", offset_y, 101);
    tick();

    frame_int = 1; tick(); frame_int = 0; tick(); frame_int = 1; tick(); frame_int = 0;
    repeat (4) tick();
    check("ovr tick", frame_tick, 1);
    model_frame();
    check("ovr x", offset_x, mox);
    check("ovr y", offset_y, moy);
    extra = 0;
    repeat (12) begin tick(); extra += int'(frame_tick); end
    check("ovr extra commits", extra, 0);
    movr = 1;
    rd(2'd3, d);
    check("ovr set", d[3], 1);
    check("ovr ctrl", d, ctrl_exp());
    wr(2'd3, 16'h0009);
    rd(2'd3, d);
    check("ovr clear", d[3], 0);
    check("ovr clr ctrl", d, ctrl_exp());

    for (int i = 0; i < 30; i++) begin
      wr(2'd0, 16'($urandom_range(0, 1400)) - 16'd400);
      wr(2'd1, 16'($urandom_range(0, 1000)) - 16'd300);
      wr(2'd2, 16'($urandom));
      wr(2'd3, {14'd0, 1'($urandom), 1'($urandom_range(0, 3) != 0)});
      repeat ($urandom_range(1, 4)) frame("rnd");
      rd(2'd2, d); check("rnd vel", d, ((mvy & 255) << 8) | (mvx & 255));
      rd(2'd0, d); check("rnd posx", int'($signed(d)), mx);
      rd(2'd3, d); check("rnd ctrl", d, ctrl_exp());
    end

    wr(2'd3, 16'h0001); wr(2'd0, 16'd40); wr(2'd1, 16'd40); wr(2'd2, 16'h0000);
    frame("pre");
    rd(2'd0, d);
    frame_int = 1;
    repeat (3) tick();
    frame_int = 0;
    repeat (2) tick();
    #2 reset = 0;
    #1;
    check("arst x", offset_x, 0);
    check("arst y", offset_y, 0);
    check("arst tick", frame_tick, 0);
    check("arst rdata", bus.rdata, 0);
    model_reset();
    tick();
    reset = 1;
    tick();
    rd(2'd3, d);
    check("arst ctrl", d, 0);
    frame("post");
    rd(2'd3, d);
    check("post cnt", d, 16'h0010);

    wr(2'd0, 16'd300); wr(2'd1, 16'd300);
    repeat (3) tick();
    check("hold x", offset_x, 0);
    check("hold y", offset_y, 0);
    frame("hold");
    check("hold cx", offset_x, 300);
    check("hold cy", offset_y, 300);

    while (mcnt != 4095) frame("cnt");
    rd(2'd3, d);
    check("cnt 4095", d[15:4], 4095);
    frame("cntw");
    rd(2'd3, d);
    check("cnt wrap", d[15:4], 0);
    check("cnt ctrl", d, ctrl_exp());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
